// File: rtl/oled_feeder_pkg.sv
// Shared types and constants for the OLED text feeder: FSM states, buffer geometry
// and the power-on banner used when OLED_FEEDER_BANNER_EN is defined.
package oled_feeder_pkg;
  localparam int ROW_W  = 2;
  localparam int COL_W  = 4;
  localparam int IDX_W  = 6;
  localparam int NCHARS = 64;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE, SCAN, ISSUE, WWAIT0, WWAIT, UPD, UWAIT0, UWAIT
  } state_t;

  // Row 0 leads, so character index 0 lives in the MSBs.
  localparam logic [NCHARS*8-1:0] BANNER = {
    "  AstroPix FW   ",
    "     KIT-ADL    ",
    {32{CHAR_SPACE}}
  };

  function automatic logic [7:0] banner_char(input logic [IDX_W-1:0] idx);
    return BANNER[(NCHARS-1-int'(idx))*8 +: 8];
  endfunction
endpackage

// File: rtl/oled_text_feeder_if.sv
// Command handshake between the text feeder (master) and the OLED character controller (slave).
interface oled_text_feeder_if;
  logic       write_start;
  logic [7:0] write_ascii_data;
  logic [8:0] write_base_addr;
  logic       write_ready;
  logic       update_start;
  logic       update_clear;
  logic       update_ready;

  modport master (
    output write_start, write_ascii_data, write_base_addr, update_start, update_clear,
    input  write_ready, update_ready
  );
  modport slave (
    input  write_start, write_ascii_data, write_base_addr, update_start, update_clear,
    output write_ready, update_ready
  );
endinterface

// File: rtl/oled_char_buf.sv
// 64x8 shadow character buffer with per-character dirty bits and a running dirty count.
// Reset contents follow OLED_FEEDER_BANNER_EN (banner + all dirty) or spaces + clean.
module oled_char_buf
  import oled_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  clr_idx_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [7:0]        rd_data_o,
  output logic [NCHARS-1:0] dirty_o,
  output logic [IDX_W:0]    dirty_cnt_o
);
  logic [NCHARS-1:0][7:0] mem_q;
  logic [NCHARS-1:0]      dirty_q, dirty_d;
  logic [IDX_W:0]         cnt_q, cnt_d;
  logic                   inc, dec;

  // Same-cycle write to the read slot is forwarded so the latched char is never stale.
  assign rd_data_o   = (we_i && waddr_i == rd_idx_i) ? wdata_i : mem_q[rd_idx_i];
  assign dirty_o     = dirty_q;
  assign dirty_cnt_o = cnt_q;

  // Set is applied after clear, so a host write always wins.
  always_comb begin
    dirty_d = dirty_q;
    if (clr_i) dirty_d[clr_idx_i] = 1'b0;
    if (we_i)  dirty_d[waddr_i]   = 1'b1;
  end

  assign inc   = we_i && !dirty_q[waddr_i];
  assign dec   = clr_i && dirty_q[clr_idx_i] && !(we_i && waddr_i == clr_idx_i);
  assign cnt_d = cnt_q + {{IDX_W{1'b0}}, inc} - {{IDX_W{1'b0}}, dec};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NCHARS; i++) begin
`ifdef OLED_FEEDER_BANNER_EN
        mem_q[i] <= banner_char(IDX_W'(i));
`else
        mem_q[i] <= CHAR_SPACE;
`endif
      end
`ifdef OLED_FEEDER_BANNER_EN
      dirty_q <= '1;
      cnt_q   <= (IDX_W+1)'(NCHARS);
`else
      dirty_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/oled_text_feeder.sv
// Pushes dirty shadow-buffer characters to the OLED controller, then requests a panel update.
// Build option OLED_FEEDER_BANNER_EN preloads a banner and a pending update at reset.
module oled_text_feeder
  import oled_feeder_pkg::*;
#(
  parameter bit AUTO_UPDATE    = 1'b1,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                char_we,
  input  logic [IDX_W-1:0]    char_addr,
  input  logic [7:0]          char_data,
  input  logic                refresh_req,
  input  logic                clear_req,
  oled_text_feeder_if.master  ctl,
  output logic                busy,
  output logic [IDX_W:0]      dirty_cnt
);
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLDOFF_LD = HW'(HOLDOFF_CYCLES);

  state_t             state_q;
  logic [IDX_W-1:0]   scan_ptr_q;
  logic [HW-1:0]      holdoff_q;
  logic               pend_upd_q, pend_clr_q;
  logic               wstart_q, ustart_q, uclr_q;
  logic [7:0]         wdata_q;
  logic [8:0]         waddr_q;
  logic [7:0]         rd_data;
  logic [NCHARS-1:0]  dirty;
  logic               any_dirty;

  oled_char_buf u_buf (
    .clk         (clk),
    .rstn        (rstn),
    .we_i        (char_we),
    .waddr_i     (char_addr),
    .wdata_i     (char_data),
    .clr_i       (state_q == ISSUE),
    .clr_idx_i   (scan_ptr_q),
    .rd_idx_i    (scan_ptr_q),
    .rd_data_o   (rd_data),
    .dirty_o     (dirty),
    .dirty_cnt_o (dirty_cnt)
  );

  assign any_dirty            = |dirty;
  assign busy                 = (state_q != IDLE) || any_dirty;
  assign ctl.write_start      = wstart_q;
  assign ctl.write_ascii_data = wdata_q;
  assign ctl.write_base_addr  = waddr_q;
  assign ctl.update_start     = ustart_q;
  assign ctl.update_clear     = uclr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      scan_ptr_q <= '0;
      holdoff_q  <= '0;
      wstart_q   <= 1'b0;
      ustart_q   <= 1'b0;
      uclr_q     <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      pend_clr_q <= 1'b0;
`ifdef OLED_FEEDER_BANNER_EN
      pend_upd_q <= 1'b1;
`else
      pend_upd_q <= 1'b0;
`endif
    end else begin
      wstart_q <= 1'b0;
      ustart_q <= 1'b0;
      uclr_q   <= 1'b0;
      if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;

      case (state_q)
        IDLE: begin
          if (enable && any_dirty) state_q <= SCAN;
          else if (enable && (pend_clr_q || pend_upd_q) && holdoff_q == '0) state_q <= UPD;
        end
        SCAN: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (dirty[scan_ptr_q]) begin
            // Outputs are registered, so the pulse and payload appear during ISSUE.
            if (ctl.write_ready) begin
              state_q  <= ISSUE;
              wstart_q <= 1'b1;
              wdata_q  <= rd_data;
              waddr_q  <= {scan_ptr_q, 3'b000};
            end
          end else begin
            scan_ptr_q <= scan_ptr_q + 1'b1;
            if (!any_dirty) state_q <= IDLE;
          end
        end
        ISSUE: begin
          scan_ptr_q <= scan_ptr_q + 1'b1;
          if (AUTO_UPDATE) pend_upd_q <= 1'b1;
          state_q <= WWAIT0;
        end
        WWAIT0: state_q <= WWAIT;
        WWAIT: begin
          if (ctl.write_ready) state_q <= (any_dirty && enable) ? SCAN : IDLE;
        end
        UPD: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (ctl.update_ready) begin
            ustart_q   <= 1'b1;
            uclr_q     <= pend_clr_q;
            pend_upd_q <= 1'b0;
            pend_clr_q <= 1'b0;
            holdoff_q  <= HOLDOFF_LD;
            state_q    <= UWAIT0;
          end
        end
        UWAIT0: state_q <= UWAIT;
        UWAIT: begin
          if (ctl.update_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Requests landing in the same cycle as an update launch are kept for the next one.
      if (refresh_req) pend_upd_q <= 1'b1;
      if (clear_req)   pend_clr_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_oled_text_feeder.sv
// Directed bench for oled_text_feeder with a small ready-dropping controller model.
module tb_oled_text_feeder;
  logic       clk = 1'b0;
  logic       rstn, enable, char_we, refresh_req, clear_req;
  logic [5:0] char_addr;
  logic [7:0] char_data;
  logic       busy;
  logic [6:0] dirty_cnt;
  logic       hold_wr = 1'b0;
  int         wcnt = 0, ucnt = 0, cyc = 0;
  int         errors = 0, checks = 0;

  logic [7:0] wd_q[$];
  logic [8:0] wa_q[$];
  int         wcyc_q[$];
  logic       uc_q[$];
  int         ucyc_q[$];

  oled_text_feeder_if ctl();

  oled_text_feeder #(.AUTO_UPDATE(1'b1), .HOLDOFF_CYCLES(10)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .char_we(char_we), .char_addr(char_addr),
    .char_data(char_data), .refresh_req(refresh_req), .clear_req(clear_req),
    .ctl(ctl), .busy(busy), .dirty_cnt(dirty_cnt)
  );

  always #5 clk = ~clk;

  // Controller model: ready drops for two cycles after each accepted start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctl.write_start) wcnt <= 2; else if (wcnt > 0) wcnt <= wcnt - 1;
    if (ctl.update_start) ucnt <= 2; else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign ctl.write_ready  = !hold_wr && (wcnt == 0);
  assign ctl.update_ready = (ucnt == 0);

  always @(negedge clk) begin
    if (ctl.write_start) begin
      wd_q.push_back(ctl.write_ascii_data);
      wa_q.push_back(ctl.write_base_addr);
      wcyc_q.push_back(cyc);
    end
    if (ctl.update_start) begin
      uc_q.push_back(ctl.update_clear);
      ucyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    char_we = 1'b1; char_addr = a; char_data = d;
    @(negedge clk);
    char_we = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int max_cyc, input string tag);
    int n = 0;
    while (wd_q.size() < target && n < max_cyc) begin @(negedge clk); n++; end
    check(tag, 32'(wd_q.size() >= target), 32'd1);
  endtask

  task automatic wait_wstart(input int max_cyc, input string tag);
    int n = 0;
    while (ctl.write_start !== 1'b1 && n < max_cyc) begin @(negedge clk); n++; end
    check(tag, 32'(ctl.write_start), 32'd1);
  endtask

  initial begin
    int nw, nu, n;
    rstn = 1'b0; enable = 1'b1; char_we = 1'b0; char_addr = '0; char_data = '0;
    refresh_req = 1'b0; clear_req = 1'b0;
    ticks(3);
    check("rst_wstart", 32'(ctl.write_start), 0);
    check("rst_ustart", 32'(ctl.update_start), 0);
    check("rst_uclear", 32'(ctl.update_clear), 0);
    check("rst_wdata", 32'(ctl.write_ascii_data), 0);
    check("rst_waddr", 32'(ctl.write_base_addr), 0);
    check("rst_dcnt", 32'(dirty_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    ticks(2);

    // 1: single char, then one plain update
    host_write(6'h00, 8'h41);
    check("t1_dcnt", 32'(dirty_cnt), 1);
    wait_writes(1, 65, "t1_latency");
    check("t1_data", 32'(wd_q[0]), 32'h41);
    check("t1_addr", 32'(wa_q[0]), 32'h000);
    ticks(40);
    check("t1_nupd", 32'(uc_q.size()), 1);
    check("t1_uclr", 32'(uc_q[0]), 0);
    // move scan pointer past index 1 so the next batch must wrap
    host_write(6'h10, 8'h42);
    wait_writes(2, 70, "pre_latency");
    check("pre_addr", 32'(wa_q[1]), 32'h080);
    ticks(60);

    // 2: wrap ordering and a single update for the batch
    nu = uc_q.size();
    host_write(6'h3F, 8'h43);
    host_write(6'h01, 8'h44);
    check("t2_dcnt2", 32'(dirty_cnt), 2);
    wait_writes(4, 140, "t2_latency");
    check("t2_addr_a", 32'(wa_q[2]), 32'h1F8);
    check("t2_addr_b", 32'(wa_q[3]), 32'h008);
    check("t2_data_b", 32'(wd_q[3]), 32'h44);
    ticks(40);
    check("t2_dcnt0", 32'(dirty_cnt), 0);
    check("t2_nupd", 32'(uc_q.size() - nu), 1);

    // 3: write_ready held low stalls the feeder
    hold_wr = 1'b1;
    host_write(6'h20, 8'h78);
    host_write(6'h21, 8'h79);
    host_write(6'h22, 8'h7A);
    ticks(200);
    check("t3_nowr", 32'(wd_q.size()), 4);
    check("t3_busy", 32'(busy), 1);
    check("t3_dcnt", 32'(dirty_cnt), 3);
    hold_wr = 1'b0;
    wait_writes(7, 60, "t3_drain");
    check("t3_gap1", 32'(wcyc_q[5] - wcyc_q[4] >= 3), 1);
    check("t3_gap2", 32'(wcyc_q[6] - wcyc_q[5] >= 3), 1);
    check("t3_addr3", 32'(wa_q[6]), 32'h110);
    ticks(40);

    // 4: host write colliding with the issue of the same index
    host_write(6'h05, 8'h51);
    wait_wstart(80, "t4_issue_seen");
    check("t4_data1", 32'(ctl.write_ascii_data), 32'h51);
    char_we = 1'b1; char_addr = 6'h05; char_data = 8'h5A;
    @(negedge clk);
    char_we = 1'b0;
    check("t4_setwins", 32'(dirty_cnt), 1);
    wait_writes(9, 80, "t4_resend");
    check("t4_data2", 32'(wd_q[8]), 32'h5A);
    check("t4_addr2", 32'(wa_q[8]), 32'h028);
    ticks(60);

    // 5: clear absorbs refresh; holdoff gates the follow-up
    nu = uc_q.size();
    refresh_req = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0; clear_req = 1'b0;
    n = 0;
    while (ctl.update_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("t5_upd_seen", 32'(ctl.update_start), 1);
    check("t5_uclr", 32'(ctl.update_clear), 1);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    ticks(40);
    check("t5_nupd", 32'(uc_q.size() - nu), 2);
    check("t5_uclr2", 32'(uc_q[nu+1]), 0);
    check("t5_holdoff", 32'(ucyc_q[nu+1] - ucyc_q[nu] >= 10), 1);

    // 6: reset while waiting for write_ready
    host_write(6'h30, 8'h61);
    host_write(6'h31, 8'h62);
    wait_wstart(80, "t6_issue_seen");
    hold_wr = 1'b1;
    ticks(2);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_wstart", 32'(ctl.write_start), 0);
    check("t6_ustart", 32'(ctl.update_start), 0);
    check("t6_wdata", 32'(ctl.write_ascii_data), 0);
    check("t6_waddr", 32'(ctl.write_base_addr), 0);
    check("t6_dcnt", 32'(dirty_cnt), 0);
    check("t6_busy", 32'(busy), 0);
    rstn = 1'b1;
    nw = wd_q.size();
    host_write(6'h00, 8'h63);
    ticks(20);
    check("t6_noready", 32'(wd_q.size() - nw), 0);
    hold_wr = 1'b0;
    wait_writes(nw + 1, 70, "t6_after");
    check("t6_data", 32'(wd_q[nw]), 32'h63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
